// File: rtl/vga_timing_if.sv
// vga_timing_if
//   Raster timing bundle driven by vga_timing_gen towards the pixel/RAM read
//   path of the logic-analyzer display.
//
//   Handshake semantics: there is no backpressure. pix_tick is a one-clk
//   "valid" qualifier for the pixel period; the consumer has no ready and must
//   accept every pixel. line_start/frame_start are one-clk strobes.
//
//   Signals:
//     pix_tick     one-clk pulse per pixel period
//     hsync/vsync  sync outputs, active level set by the generator parameters
//     video_on     counters inside the visible area
//     pixel_x/y    horizontal / vertical counters (CNT_W bits)
//     line_start   one-clk pulse at the start of each line
//     frame_start  one-clk pulse at the start of each frame
//
//   Modports: master = generator side, slave = consumer side.
interface vga_timing_if #(
  parameter int CNT_W = 12
);
  logic             pix_tick;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             line_start;
  logic             frame_start;

  modport master (
    output pix_tick, hsync, vsync, video_on,
    output pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    input pix_tick, hsync, vsync, video_on,
    input pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster sync generator. An integer divider turns the system
//   clock into a pixel tick; horizontal/vertical counters advance on that tick
//   and hsync/vsync/video_on are decoded from the counters with selectable
//   sync polarity.
//
//   Ports:
//     clk  system clock (single clock domain)
//     rst  synchronous, active-high reset
//     vga  vga_timing_if.master: pix_tick, hsync, vsync, video_on, pixel_x,
//          pixel_y, line_start, frame_start (all registered)
//
//   Optional feature, macro VGA_TIMING_SYNC_DLY_EN:
//     when defined, hsync/vsync/video_on pass through a SYNC_DLY-stage shift
//     register advanced on pixel ticks, so they lag pixel_x/pixel_y by
//     SYNC_DLY pixels (to cover RAM/ROM read latency). The strobes are never
//     delayed. When undefined, decode outputs are aligned with the counters.
module vga_timing_gen #(
  parameter int CNT_W    = 12,
  parameter int CLK_DIV  = 2,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int SYNC_DLY = 2
) (
  input  logic        clk,
  input  logic        rst,
  vga_timing_if.master vga
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  generate
    if ((H_TOT - 1) > ((1 << CNT_W) - 1)) begin : g_h_chk
      $error("vga_timing_gen: H_TOT-1 does not fit in CNT_W bits");
    end
    if ((V_TOT - 1) > ((1 << CNT_W) - 1)) begin : g_v_chk
      $error("vga_timing_gen: V_TOT-1 does not fit in CNT_W bits");
    end
  endgenerate

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_DISP);
  localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_DISP + H_FP);
  localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_DISP + V_FP);
  localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_DISP + V_FP + V_SYNC);

  localparam logic H_ACT = (H_POL != 0);
  localparam logic V_ACT = (V_POL != 0);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic             pix_tick_r;
  logic [CNT_W-1:0] x_r;
  logic [CNT_W-1:0] y_r;
  logic [CNT_W-1:0] x_next;
  logic [CNT_W-1:0] y_next;
  logic             x_wrap;
  logic             y_wrap;
  logic             hs_next;
  logic             vs_next;
  logic             vo_next;
  logic             hs_r;
  logic             vs_r;
  logic             vo_r;
  logic             ls_r;
  logic             fs_r;
  // Set by reset so both strobes fire once on the first clk after release.
  logic             first_r;

  always_comb begin
    div_next = (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);

    x_next = x_r;
    y_next = y_r;
    x_wrap = 1'b0;
    y_wrap = 1'b0;
    if (pix_tick_r) begin
      if (x_r == H_MAX) begin
        x_next = '0;
        x_wrap = 1'b1;
        if (y_r == V_MAX) begin
          y_next = '0;
          y_wrap = 1'b1;
        end else begin
          y_next = y_r + CNT_W'(1);
        end
      end else begin
        x_next = x_r + CNT_W'(1);
      end
    end

    // Decode the next-state counters so the registered outputs line up with
    // pixel_x/pixel_y on the same clk.
    vo_next = (x_next < H_VIS) && (y_next < V_VIS);
    hs_next = ((x_next >= H_SS) && (x_next < H_SE)) ? H_ACT : ~H_ACT;
    vs_next = ((y_next >= V_SS) && (y_next < V_SE)) ? V_ACT : ~V_ACT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      pix_tick_r <= 1'b0;
      x_r        <= '0;
      y_r        <= '0;
      vo_r       <= 1'b0;
      hs_r       <= ~H_ACT;
      vs_r       <= ~V_ACT;
      ls_r       <= 1'b0;
      fs_r       <= 1'b0;
      first_r    <= 1'b1;
    end else begin
      div_cnt    <= div_next;
      pix_tick_r <= (div_next == DIV_MAX);
      x_r        <= x_next;
      y_r        <= y_next;
      vo_r       <= vo_next;
      hs_r       <= hs_next;
      vs_r       <= vs_next;
      first_r    <= 1'b0;
      ls_r       <= first_r | x_wrap;
      fs_r       <= first_r | (x_wrap & y_wrap);
    end
  end

`ifdef VGA_TIMING_SYNC_DLY_EN
  // Stage 0 takes the decode of the pixel just left; stage SYNC_DLY-1 thus
  // holds the decode of the pixel SYNC_DLY positions behind the counters.
  logic [SYNC_DLY-1:0] hs_dly;
  logic [SYNC_DLY-1:0] vs_dly;
  logic [SYNC_DLY-1:0] vo_dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_dly <= {SYNC_DLY{~H_ACT}};
      vs_dly <= {SYNC_DLY{~V_ACT}};
      vo_dly <= '0;
    end else if (pix_tick_r) begin
      for (int i = SYNC_DLY - 1; i > 0; i--) begin
        hs_dly[i] <= hs_dly[i-1];
        vs_dly[i] <= vs_dly[i-1];
        vo_dly[i] <= vo_dly[i-1];
      end
      hs_dly[0] <= hs_r;
      vs_dly[0] <= vs_r;
      vo_dly[0] <= vo_r;
    end
  end

  assign vga.hsync    = hs_dly[SYNC_DLY-1];
  assign vga.vsync    = vs_dly[SYNC_DLY-1];
  assign vga.video_on = vo_dly[SYNC_DLY-1];
`else
  assign vga.hsync    = hs_r;
  assign vga.vsync    = vs_r;
  assign vga.video_on = vo_r;
`endif

  assign vga.pix_tick    = pix_tick_r;
  assign vga.pixel_x     = x_r;
  assign vga.pixel_y     = y_r;
  assign vga.line_start  = ls_r;
  assign vga.frame_start = fs_r;

endmodule
